bcd_game_timer: RTL and testbench
=================================

Name: bcd_game_timer

Overview:
- Parametrised seconds timer for the game board. Replaces the fixed two-digit 0-9/0-6 counter pair.
- Contains an internal one-second prescaler, DIGITS cascaded BCD digits, and selectable count-up or count-down mode.
- Supports start, pause, load and clear controls.
- Produces a per-second tick pulse and an expiry indication.
- The count output feeds the HEX digit decoders directly, one nibble per digit.

Parameters:
- CLK_HZ, 50_000_000, CLOCK_50 cycles per second; prescaler terminal value is CLK_HZ-1.
- DIGITS, 2, number of BCD digits (1..4); count width is 4*DIGITS.
- LIMIT, 60, up-mode terminal value in seconds (binary integer, 1..10^DIGITS-1).
- WRAP, 0:
  - 0: up mode stops at LIMIT and holds expiry.
  - 1: up mode wraps to 0 at LIMIT and pulses expiry.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high; clock CLOCK_50
- start  in  1  run request (level, acted on per cycle)
- pause  in  1  pause request
- clear  in  1  return to IDLE, count := 0
- load  in  1  load count from load_value
- down  in  1  mode select; 1 = count down; sampled only on IDLE->RUN
- load_value  in  4*DIGITS  BCD preset; digit i at bits [4i+3:4i]
- count  out  4*DIGITS  current BCD count, digit 0 least significant
- tick  out  1  one-cycle pulse per elapsed second while RUN
- expired  out  1  expiry indication
- running  out  1  high in RUN

Behaviour:
- Reset sets all of the following:
  - state IDLE, count 0, prescaler 0
  - tick 0, expired 0, running 0
  - latched mode up
- States are IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Control priority per cycle is reset > clear > load > start > pause.
- clear (any state): state IDLE, count 0, prescaler 0, expired 0.
- load (IDLE, PAUSED or EXPIRED): count := load_value with each digit >9 clamped to 9; state IDLE; prescaler 0; expired 0. load is ignored in RUN.
- IDLE + start:
  - Latch down, prescaler := 0, state RUN.
  - If down=1 and count==0, go to EXPIRED instead; no tick is issued.
- RUN + pause: state PAUSED. The prescaler holds its value, so the partial second is preserved. start is ignored in RUN.
- PAUSED + start: state RUN; the prescaler resumes from its held value.
- EXPIRED: start and pause are ignored. Only clear, load or reset leave this state.
- Prescaler (RUN only):
  - Increments each cycle.
  - When it equals CLK_HZ-1, it goes to 0 and tick=1 on the following cycle.
  - count updates on the same edge that raises tick, so count and tick change together.
- Up step:
  - BCD increment with ripple carry: digit 9 -> 0 with carry into the next digit.
  - If the new value equals LIMIT:
    - WRAP=0: count := LIMIT (BCD), state EXPIRED, expired=1 level.
    - WRAP=1: count := 0, expired=1 for one cycle coincident with tick, remain RUN.
- Down step:
  - BCD decrement with borrow: digit 0 -> 9 with borrow from the next digit.
  - When the new value is 0: state EXPIRED, expired=1 level.
- A tick and a pause in the same cycle: the count update is applied, tick=1, then state PAUSED.
- running=1 exactly when state==RUN. tick is never asserted outside a RUN-originated step.
- Count never holds a digit >9. The up-mode all-9s value with LIMIT above it is unreachable by the parameter rule.
- Reset mid-run: on the next edge the block is in IDLE with count 0 and the prescaler cleared.

Test Plan:
All cases use CLK_HZ=4, DIGITS=2, LIMIT=12.
1. reset, start=1 one cycle, down=0:
   - tick every 4 cycles.
   - count runs 0x00, 0x01 ... 0x09, 0x10, 0x11, then 0x12 with expired=1 held.
   - running=0 after expiry; further start is ignored.
2. WRAP=1 build, same stimulus:
   - count 0x11 -> 0x00 with a one-cycle expired pulse coincident with tick.
   - Counting continues; running stays 1.
3. load=1 with load_value=0x3A, then down=1 and start:
   - count preset is 0x39.
   - Decrements 0x39, 0x38 ... 0x30, 0x29 with the borrow correct.
   - At 0x00 the block enters EXPIRED with expired=1.
4. Pause 2 cycles into a second, hold 10 cycles, then start:
   - No tick while PAUSED.
   - Next tick arrives 2 cycles after resume; count is unchanged across the pause.
5. start with down=1 and count=0x00:
   - Next cycle expired=1, no tick, running=0.
6. During RUN, assert clear and load together:
   - clear wins: count 0x00, state IDLE.
   - Separately, reset asserted mid-second with pause: all outputs 0 on the next edge.

Source files
------------

// File: rtl/bcd_game_timer_if.sv
// Control/status bundle for the BCD game timer.
// master: game logic driving controls; slave: the timer itself.
interface bcd_game_timer_if #(
    parameter int DIGITS = 2
);
    logic                start;
    logic                pause;
    logic                clear;
    logic                load;
    logic                down;
    logic [4*DIGITS-1:0] load_value;
    logic [4*DIGITS-1:0] count;
    logic                tick;
    logic                expired;
    logic                running;

    modport master (
        output start, pause, clear, load, down, load_value,
        input  count, tick, expired, running
    );

    modport slave (
        input  start, pause, clear, load, down, load_value,
        output count, tick, expired, running
    );
endinterface

// File: rtl/bcd_game_timer.sv
// Seconds timer with internal prescaler and DIGITS cascaded BCD digits.
// Ports: CLOCK_50, reset (sync, active-high), bus (slave modport):
//   start/pause/clear/load/down/load_value in; count/tick/expired/running out.
module bcd_game_timer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIGITS = 2,
    parameter int LIMIT  = 60,
    parameter bit WRAP   = 1'b0
) (
    input logic             CLOCK_50,
    input logic             reset,
    bcd_game_timer_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PSC_END = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] LIMIT_BCD = to_bcd(LIMIT);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic carry;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic borrow;
        r = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Out-of-range preset digits are forced to 9 so count stays valid BCD.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    state_t        state, state_next;
    logic [W-1:0]  cnt, cnt_next, stepped;
    logic [PW-1:0] psc, psc_next;
    logic          mode_down, mode_down_next;
    logic          tick_q, tick_next;
    logic          expired_q, expired_next;
    logic          running_q;

    assign stepped = mode_down ? bcd_dec(cnt) : bcd_inc(cnt);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        psc_next       = psc;
        mode_down_next = mode_down;
        tick_next      = 1'b0;
        expired_next   = (state == EXPIRED);

        if (bus.clear) begin
            state_next   = IDLE;
            cnt_next     = '0;
            psc_next     = '0;
            expired_next = 1'b0;
        end else if (bus.load && state != RUN) begin
            state_next   = IDLE;
            cnt_next     = bcd_clamp(bus.load_value);
            psc_next     = '0;
            expired_next = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_down_next = bus.down;
                        psc_next       = '0;
                        if (bus.down && cnt == '0) begin
                            state_next   = EXPIRED;
                            expired_next = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start) state_next = RUN;
                end
                RUN: begin
                    if (bus.pause) state_next = PAUSED;
                    if (psc == PSC_END) begin
                        psc_next  = '0;
                        tick_next = 1'b1;
                        cnt_next  = stepped;
                        if (mode_down) begin
                            if (stepped == '0) begin
                                state_next   = EXPIRED;
                                expired_next = 1'b1;
                            end
                        end else if (stepped == LIMIT_BCD) begin
                            // Expiry overrides a same-cycle pause.
                            expired_next = 1'b1;
                            if (WRAP) cnt_next = '0;
                            else state_next = EXPIRED;
                        end
                    end else begin
                        psc_next = psc + PW'(1);
                    end
                end
                EXPIRED: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            psc       <= '0;
            mode_down <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            psc       <= psc_next;
            mode_down <= mode_down_next;
            tick_q    <= tick_next;
            expired_q <= expired_next;
            running_q <= (state_next == RUN);
        end
    end

    assign bus.count   = cnt;
    assign bus.tick    = tick_q;
    assign bus.expired = expired_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_bcd_game_timer.sv
// Self-checking bench: WRAP=0 and WRAP=1 timers driven in lockstep
// and compared every cycle against a seconds-level reference model.
module tb_bcd_game_timer;
    localparam int HZ  = 4;
    localparam int DG  = 2;
    localparam int LIM = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, pause, clear, load, down;
    logic [7:0] load_value;

    int vectors = 0;
    int miscompares = 0;

    // Reference state per instance (0: WRAP=0, 1: WRAP=1).
    // mode: 0 idle, 1 running, 2 paused, 3 expired; val is plain seconds.
    int m_mode[2];
    int m_val[2];
    int m_elapsed[2];
    int m_dn[2];
    int m_tick[2];
    int m_exp[2];

    bcd_game_timer_if #(.DIGITS(DG)) b0 ();
    bcd_game_timer_if #(.DIGITS(DG)) b1 ();

    assign b0.start = start;
    assign b0.pause = pause;
    assign b0.clear = clear;
    assign b0.load = load;
    assign b0.down = down;
    assign b0.load_value = load_value;
    assign b1.start = start;
    assign b1.pause = pause;
    assign b1.clear = clear;
    assign b1.load = load;
    assign b1.down = down;
    assign b1.load_value = load_value;

    bcd_game_timer #(
        .CLK_HZ(HZ), .DIGITS(DG), .LIMIT(LIM), .WRAP(1'b0)
    ) dut0 (
        .CLOCK_50(clk), .reset(reset), .bus(b0.slave)
    );

    bcd_game_timer #(
        .CLK_HZ(HZ), .DIGITS(DG), .LIMIT(LIM), .WRAP(1'b1)
    ) dut1 (
        .CLOCK_50(clk), .reset(reset), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        int r;
        r = 0;
        for (int i = 0; i < DG; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int preset_secs(input logic [7:0] lv);
        int lo;
        int hi;
        lo = int'(lv[3:0]);
        hi = int'(lv[7:4]);
        if (lo > 9) lo = 9;
        if (hi > 9) hi = 9;
        return hi * 10 + lo;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_mode[k] = 0;
                m_val[k] = 0;
                m_elapsed[k] = 0;
                m_dn[k] = 0;
                m_tick[k] = 0;
                m_exp[k] = 0;
            end else begin
                int nmode;
                m_tick[k] = 0;
                m_exp[k] = (m_mode[k] == 3) ? 1 : 0;
                if (clear) begin
                    m_mode[k] = 0;
                    m_val[k] = 0;
                    m_elapsed[k] = 0;
                    m_exp[k] = 0;
                end else if (load && m_mode[k] != 1) begin
                    m_mode[k] = 0;
                    m_val[k] = preset_secs(load_value);
                    m_elapsed[k] = 0;
                    m_exp[k] = 0;
                end else if (m_mode[k] == 0) begin
                    if (start) begin
                        m_dn[k] = down ? 1 : 0;
                        m_elapsed[k] = 0;
                        if (down && m_val[k] == 0) begin
                            m_mode[k] = 3;
                            m_exp[k] = 1;
                        end else begin
                            m_mode[k] = 1;
                        end
                    end
                end else if (m_mode[k] == 2) begin
                    if (start) m_mode[k] = 1;
                end else if (m_mode[k] == 1) begin
                    nmode = pause ? 2 : 1;
                    m_elapsed[k]++;
                    if (m_elapsed[k] == HZ) begin
                        m_elapsed[k] = 0;
                        m_tick[k] = 1;
                        if (m_dn[k] != 0) begin
                            m_val[k] = m_val[k] - 1;
                            if (m_val[k] == 0) begin
                                nmode = 3;
                                m_exp[k] = 1;
                            end
                        end else begin
                            m_val[k] = (m_val[k] + 1) % 100;
                            if (m_val[k] == LIM) begin
                                m_exp[k] = 1;
                                if (k == 1) m_val[k] = 0;
                                else nmode = 3;
                            end
                        end
                    end
                    m_mode[k] = nmode;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("w0.count", 32'(b0.count), 32'(to_bcd(m_val[0])));
        chk("w0.tick", 32'(b0.tick), 32'(m_tick[0]));
        chk("w0.expired", 32'(b0.expired), 32'(m_exp[0]));
        chk("w0.running", 32'(b0.running), 32'(m_mode[0] == 1));
        chk("w1.count", 32'(b1.count), 32'(to_bcd(m_val[1])));
        chk("w1.tick", 32'(b1.tick), 32'(m_tick[1]));
        chk("w1.expired", 32'(b1.expired), 32'(m_exp[1]));
        chk("w1.running", 32'(b1.running), 32'(m_mode[1] == 1));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        down = 1'b0;
        load_value = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_val[k] = 0;
            m_elapsed[k] = 0;
            m_dn[k] = 0;
            m_tick[k] = 0;
            m_exp[k] = 0;
        end
        step();
        step();
        reset = 1'b0;
        step();

        // Count up to the limit; WRAP instance rolls over and keeps going.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (LIM * HZ + 6) step();
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;

        // Preset with an invalid digit, then count down to zero.
        clear = 1'b1;
        step();
        clear = 1'b0;
        load = 1'b1;
        load_value = 8'h3A;
        step();
        load = 1'b0;
        down = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        down = 1'b0;
        repeat (40 * HZ + 4) step();

        // Pause part way through a second and resume.
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (HZ + 1) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 * HZ) step();

        // Down start from zero expires immediately.
        clear = 1'b1;
        step();
        clear = 1'b0;
        down = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        down = 1'b0;
        repeat (3) step();

        // clear beats load during RUN; reset mid-second with pause.
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (HZ + 2) step();
        clear = 1'b1;
        load = 1'b1;
        load_value = 8'h45;
        step();
        clear = 1'b0;
        load = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (HZ + 2) step();
        pause = 1'b1;
        reset = 1'b1;
        step();
        pause = 1'b0;
        reset = 1'b0;
        repeat (2) step();

        // Random control traffic.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            clear = ($urandom_range(0, 79) == 0);
            load = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 11) == 0);
            down = $urandom_range(0, 1) == 1;
            load_value = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
